sym_fir_pipe: RTL and testbench



---
 rtl/sym_fir_pipe.sv | 232 +++++++++++++++++++++++
 tb/tb_sym_fir_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_fir_pipe.sv
// sym_fir_pipe: fully pipelined even-symmetric FIR filter with a double-buffered
// coefficient bank. It accepts one sample per clk. A per-sample valid bit travels
// beside the data through every stage.
//
// Optional build macro: SYM_FIR_SAT_EN. When it is defined, the output is clamped
// to the OW range and sat_flag is added. When it is not defined, the output wraps.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   clr            synchronous flush of the delay line, fill count and valids
//   in_valid       in_data carries a new sample this cycle
//   in_data        signed input sample (DW bits)
//   coef_we        write coef_wdata into shadow[coef_addr]
//   coef_addr      shadow index, 0..TAPS/2-1
//   coef_wdata     signed coefficient (CW bits, FRAC fractional bits)
//   coef_commit    copy the whole shadow bank into the active bank
//   out_valid      single-cycle pulse for each filtered sample
//   out_data       signed filtered sample; holds its value between pulses
//   busy           a valid sample is somewhere in the pipeline
//   sat_flag       (SYM_FIR_SAT_EN only) the current output was clamped
module sym_fir_pipe #(
  parameter int unsigned DW   = 16,
  parameter int unsigned OW   = 16,
  parameter int unsigned CW   = 20,
  parameter int unsigned TAPS = 32,
  parameter int unsigned FRAC = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic signed [DW-1:0]          in_data,
  input  logic                          coef_we,
  input  logic [$clog2(TAPS/2)-1:0]     coef_addr,
  input  logic signed [CW-1:0]          coef_wdata,
  input  logic                          coef_commit,
  output logic                          out_valid,
  output logic signed [OW-1:0]          out_data,
  output logic                          busy
`ifdef SYM_FIR_SAT_EN
  ,
  output logic                          sat_flag
`endif
);

  localparam int unsigned HT   = TAPS / 2;
  localparam int unsigned A    = $clog2(HT);
  localparam int unsigned PW   = DW + 1;
  localparam int unsigned MW   = DW + 1 + CW;
  localparam int unsigned ACCW = MW + A;
  localparam int unsigned FW   = $clog2(TAPS);
  localparam int unsigned RW   = ACCW + 1 - FRAC;

  // Number of adder-tree nodes at a given level (level 0 = products).
  function automatic int unsigned tree_cnt(input int unsigned lvl);
    int unsigned n;
    n = HT;
    for (int unsigned i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Offset of the first node of a level in the flat node array.
  function automatic int unsigned tree_off(input int unsigned lvl);
    int unsigned o;
    o = 0;
    for (int unsigned i = 0; i < lvl; i++) o = o + tree_cnt(i);
    return o;
  endfunction

  localparam int unsigned NNODE = tree_off(A + 1);
  localparam logic signed [ACCW:0] RND = (ACCW + 1)'(1) << (FRAC - 1);

  logic signed [DW-1:0]   r_dly    [TAPS-1];
  logic signed [DW-1:0]   w_x      [TAPS];
  logic [FW-1:0]          r_fill;
  logic                   w_full;
  logic signed [PW-1:0]   r_p      [HT];
  logic                   r_vp;
  logic signed [CW-1:0]   r_shadow [HT];
  logic signed [CW-1:0]   r_active [HT];
  logic signed [MW-1:0]   w_prod   [HT];
  logic signed [ACCW-1:0] r_node   [NNODE];
  logic [A:0]             r_vt;
  logic signed [ACCW-1:0] w_acc;
  logic signed [ACCW:0]   w_rnd;
  logic signed [RW-1:0]   w_r;
  logic signed [OW-1:0]   w_o;
  logic                   w_unused;

  // Tap vector: the current input followed by the delay line.
  always_comb begin
    w_x[0] = in_data;
    for (int k = 1; k < int'(TAPS); k++) w_x[k] = r_dly[k-1];
  end

  assign w_full = (r_fill == FW'(TAPS - 1));

  // Delay line and warm-up counter. They advance only on accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(TAPS) - 1; k++) r_dly[k] <= '0;
      r_fill <= '0;
    end else if (clr) begin
      for (int k = 0; k < int'(TAPS) - 1; k++) r_dly[k] <= '0;
      r_fill <= '0;
    end else if (in_valid) begin
      r_dly[0] <= in_data;
      for (int k = 1; k < int'(TAPS) - 1; k++) r_dly[k] <= r_dly[k-1];
      if (!w_full) r_fill <= r_fill + FW'(1);
    end
  end

  // Pre-add stage: fold the symmetric taps pairwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(HT); k++) r_p[k] <= '0;
      r_vp <= 1'b0;
    end else begin
      r_vp <= in_valid & w_full & ~clr;
      if (in_valid) begin
        for (int k = 0; k < int'(HT); k++)
          r_p[k] <= PW'(w_x[k]) + PW'(w_x[int'(TAPS) - 1 - k]);
      end
    end
  end

  // Coefficient banks. Commit samples the shadow before any same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(HT); k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      if (coef_we && (32'(coef_addr) < HT)) r_shadow[coef_addr] <= coef_wdata;
      if (coef_commit) begin
        for (int k = 0; k < int'(HT); k++) r_active[k] <= r_shadow[k];
      end
    end
  end

  // Full-precision products.
  always_comb begin
    for (int k = 0; k < int'(HT); k++) w_prod[k] = MW'(r_p[k]) * MW'(r_active[k]);
  end

  // Multiply stage (tree level 0). Nodes are held at ACCW bits; the upper bits
  // are pure sign extension and fall away where a level does not need them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(HT); k++) r_node[k] <= '0;
    end else begin
      for (int k = 0; k < int'(HT); k++) r_node[k] <= ACCW'(w_prod[k]);
    end
  end

  // Registered adder-tree levels. An odd leftover node is passed through.
  for (genvar l = 1; l <= int'(A); l++) begin : g_lvl
    localparam int unsigned NI = tree_cnt(l - 1);
    localparam int unsigned NO = tree_cnt(l);
    localparam int unsigned OI = tree_off(l - 1);
    localparam int unsigned OO = tree_off(l);
    for (genvar j = 0; j < int'(NO); j++) begin : g_node
      if (2 * j + 1 < int'(NI)) begin : g_add
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_node[OO+j] <= '0;
          else     r_node[OO+j] <= r_node[OI+2*j] + r_node[OI+2*j+1];
        end
      end else begin : g_pass
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_node[OO+j] <= '0;
          else     r_node[OO+j] <= r_node[OI+2*j];
        end
      end
    end
  end

  // Valid bits for the multiply stage and each tree level; clr kills them all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vt <= '0;
    else     r_vt <= {r_vt[A-1:0], r_vp} & {(A + 1){~clr}};
  end

  // Round half up, then drop the fractional bits.
  assign w_acc = r_node[NNODE-1];
  assign w_rnd = (ACCW + 1)'(w_acc) + RND;
  assign w_r   = w_rnd[ACCW:FRAC];

`ifdef SYM_FIR_SAT_EN
  localparam logic signed [RW-1:0] OMAX = RW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] OMIN = RW'(-(64'sd1 <<< (OW - 1)));
  logic w_sat;

  always_comb begin
    w_sat = 1'b0;
    w_o   = OW'(w_r);
    if (w_r > OMAX) begin
      w_sat = 1'b1;
      w_o   = OW'(OMAX);
    end else if (w_r < OMIN) begin
      w_sat = 1'b1;
      w_o   = OW'(OMIN);
    end
  end

  assign w_unused = ^w_rnd[FRAC-1:0];
`else
  // Two's-complement wrap: keep the low OW bits of the rounded value.
  assign w_o      = w_r[OW-1:0];
  assign w_unused = ^{w_rnd[FRAC-1:0], w_r[RW-1:OW]};
`endif

  // Output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef SYM_FIR_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      out_valid <= r_vt[A] & ~clr;
      if (r_vt[A] && !clr) out_data <= w_o;
`ifdef SYM_FIR_SAT_EN
      sat_flag  <= r_vt[A] & ~clr & w_sat;
`endif
    end
  end

  assign busy = r_vp | (|r_vt) | out_valid;

endmodule

// File: tb/tb_sym_fir_pipe.sv
// Directed testbench for sym_fir_pipe (default parameters, TAPS=32, latency 7).
module tb_sym_fir_pipe;

  localparam int unsigned DW  = 16;
  localparam int unsigned OW  = 16;
  localparam int unsigned CW  = 20;
  localparam int unsigned AW  = 4;
  localparam longint      LAT = 7;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 clr = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic                 coef_commit = 1'b0;
  logic                 out_valid;
  logic signed [OW-1:0] out_data;
  logic                 busy;
`ifdef SYM_FIR_SAT_EN
  logic                 sat_flag;
`endif

  sym_fir_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_commit (coef_commit),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .busy        (busy)
`ifdef SYM_FIR_SAT_EN
    ,
    .sat_flag    (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  longint      cyc    = 0;
  longint      last_cyc;

  longint ev_cyc[$];
  longint ev_dat[$];
  bit     ev_sat[$];
  longint exp_cyc[$];
  longint exp_dat[$];
  bit     exp_sat[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse together with the cycle on which it appeared.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      ev_cyc.push_back(cyc);
      ev_dat.push_back(longint'(out_data));
`ifdef SYM_FIR_SAT_EN
      ev_sat.push_back(sat_flag);
`else
      ev_sat.push_back(1'b0);
`endif
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: the inputs set now are captured at the next posedge, and the
  // single-cycle controls fall back to idle afterwards.
  task automatic step();
    @(negedge clk);
    in_valid    = 1'b0;
    coef_we     = 1'b0;
    coef_commit = 1'b0;
    clr         = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input longint d);
    in_valid = 1'b1;
    in_data  = DW'(d);
    last_cyc = cyc;
    step();
  endtask

  task automatic wcoef(input int a, input longint v);
    coef_we    = 1'b1;
    coef_addr  = AW'(a);
    coef_wdata = CW'(v);
    step();
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    step();
  endtask

  task automatic clear_q();
    ev_cyc.delete(); ev_dat.delete(); ev_sat.delete();
    exp_cyc.delete(); exp_dat.delete(); exp_sat.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    clear_q();
  endtask

  task automatic expect_ev(input longint c, input longint d, input bit s);
    exp_cyc.push_back(c);
    exp_dat.push_back(d);
    exp_sat.push_back(s);
  endtask

  task automatic verify_events(input string tag);
    int n;
    check_eq({tag, " count"}, longint'(ev_cyc.size()), longint'(exp_cyc.size()));
    n = (ev_cyc.size() < exp_cyc.size()) ? ev_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s cyc[%0d]", tag, i), ev_cyc[i], exp_cyc[i]);
      check_eq($sformatf("%s data[%0d]", tag, i), ev_dat[i], exp_dat[i]);
`ifdef SYM_FIR_SAT_EN
      check_eq($sformatf("%s sat[%0d]", tag, i), longint'(ev_sat[i]), longint'(exp_sat[i]));
`endif
    end
    clear_q();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint c31;

    // Reset values.
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst out_valid", longint'(out_valid), 0);
    check_eq("rst out_data", longint'(out_data), 0);
    check_eq("rst busy", longint'(busy), 0);
    rst = 1'b0;
    step();
    clear_q();

    // Warm-up: 31 samples give nothing; the 32nd gives one output at +7.
    for (int i = 0; i < 31; i++) push(1000 + i);
    idle(12);
    verify_events("warmup31");
    push(5);
    expect_ev(last_cyc + LAT, 0, 1'b0);
    idle(12);
    verify_events("warmup32");

    // Impulse through active[0] = 1.0: the 100 appears on entry and again at delay[30].
    do_reset();
    wcoef(0, 65536);
    commit();
    for (int i = 0; i < 31; i++) push(0);
    push(100);
    c31 = last_cyc;
    for (int i = 0; i < 40; i++) push(0);
    idle(10);
    for (int i = 0; i < 41; i++) expect_ev(c31 + LAT + i, (i == 0 || i == 31) ? 100 : 0, 1'b0);
    verify_events("impulse");

    // Round half up with coef 0.5: p = 1,-1,3,-3,0 -> 1,0,2,-1,0.
    do_reset();
    wcoef(0, 32768);
    commit();
    push(1); push(-1); push(3); push(-3);
    c31 = 0;
    for (int n = 4; n < 36; n++) begin
      push(0);
      if (n == 31) c31 = last_cyc;
    end
    idle(10);
    expect_ev(c31 + LAT + 0, 1, 1'b0);
    expect_ev(c31 + LAT + 1, 0, 1'b0);
    expect_ev(c31 + LAT + 2, 2, 1'b0);
    expect_ev(c31 + LAT + 3, -1, 1'b0);
    expect_ev(c31 + LAT + 4, 0, 1'b0);
    verify_events("round");

    // All coef = 1 LSB, x = 32767: (1048544 + 32768) >> 16 = 16.
    do_reset();
    for (int a = 0; a < 16; a++) wcoef(a, 1);
    commit();
    for (int i = 0; i < 32; i++) push(32767);
    expect_ev(last_cyc + LAT, 16, 1'b0);
    idle(10);
    verify_events("symmetry");

    // All coef = 1.0, x = 20000: the result is 640000, which overflows 16 bits.
    do_reset();
    for (int a = 0; a < 16; a++) wcoef(a, 65536);
    commit();
    for (int i = 0; i < 32; i++) push(20000);
`ifdef SYM_FIR_SAT_EN
    expect_ev(last_cyc + LAT, 32767, 1'b1);
`else
    expect_ev(last_cyc + LAT, -15360, 1'b0);
`endif
    idle(10);
    verify_events("overflow");

    // Asynchronous reset with samples in flight clears the outputs at once.
    push(20000); push(20000); push(20000);
    check_eq("midrst busy before", longint'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst out_data", longint'(out_data), 0);
    check_eq("midrst out_valid", longint'(out_valid), 0);
    check_eq("midrst busy", longint'(busy), 0);
    @(negedge clk);
    do_reset();
    idle(10);
    verify_events("midrst");

    // Double buffer: shadow writes without commit change nothing. The commit takes
    // effect from the sample driven in the commit cycle, and a write in that
    // cycle is not part of the committed set.
    do_reset();
    wcoef(0, 65536);
    commit();
    c31 = 0;
    for (int n = 0; n < 50; n++) begin
      if (n == 36) begin coef_we = 1'b1; coef_addr = AW'(0); coef_wdata = CW'(0); end
      if (n == 37) begin coef_we = 1'b1; coef_addr = AW'(1); coef_wdata = CW'(131072); end
      if (n == 45) begin
        coef_commit = 1'b1;
        coef_we = 1'b1; coef_addr = AW'(2); coef_wdata = CW'(65536);
      end
      push(n);
      if (n == 31) c31 = last_cyc;
    end
    idle(10);
    for (int n = 31; n < 50; n++)
      expect_ev(c31 + LAT + (n - 31), (n < 45) ? (2 * n - 31) : (4 * n - 62), 1'b0);
    verify_events("dblbuf");

    // A gap in in_valid carries through to the output with the same spacing.
    do_reset();
    wcoef(0, 65536);
    commit();
    for (int n = 0; n < 31; n++) push(n);
    push(1000);
    expect_ev(last_cyc + LAT, 1000, 1'b0);
    idle(1);
    push(2000);
    expect_ev(last_cyc + LAT, 2001, 1'b0);
    idle(10);
    verify_events("gap");

    // clr with 3 samples in flight (and a sample offered in the same cycle).
    push(5); push(6); push(7);
    check_eq("clr busy before", longint'(busy), 1);
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = DW'(999);
    step();
    check_eq("clr busy after", longint'(busy), 0);
    idle(12);
    verify_events("clr flush");
    push(7);
    for (int i = 0; i < 30; i++) push(0);
    idle(10);
    verify_events("clr refill31");
    push(50);
    expect_ev(last_cyc + LAT, 57, 1'b0);
    idle(10);
    verify_events("clr refill32");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
